// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate-decode pipeline stage.
// Format tags, pipe occupancy states and the XLEN legality check live here.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_Z    = 3'd7
    } fmt_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    function automatic bit xlen_ok(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_decode_pipe_if.sv
// Valid/ready bundle between fetch and the immediate-decode stage outputs.
// The slave modport is the stage's view; master is the surrounding pipeline.
interface imm_decode_pipe_if
    import imm_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    fmt_t            out_fmt;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc,
        output out_imm, out_fmt, out_target, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc,
        input  out_imm, out_fmt, out_target, out_illegal
    );
endinterface

// File: rtl/imm_decode_comb.sv
// Combinational instruction -> {immediate, format, illegal} decoder.
// Sign extension always comes from instr[31]; shamt and zimm are zero-extended.
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit EN_ZICSR = 1'b1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_t            fmt,
    output logic            illegal
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic       is_sh;
    logic       sh_hi_ok;

    always_comb begin
        opc      = instr[6:0];
        f3       = instr[14:12];
        is_sh    = (f3 == 3'b001) || (f3 == 3'b101);
        // only SRAI-style shifts may set instr[30]
        sh_hi_ok = (instr[31:26] == 6'b000000) ||
                   ((f3 == 3'b101) && (instr[31:26] == 6'b010000));
        imm      = '0;
        fmt      = FMT_NONE;
        illegal  = 1'b0;
        unique case (opc)
            OPC_LOAD, OPC_JALR: begin
                fmt = FMT_I;
                imm = XLEN'($signed(instr[31:20]));
            end
            OPC_OP_IMM: begin
                if (is_sh) begin
                    fmt = FMT_SH;
                    if (XLEN == 64) begin
                        imm     = XLEN'(instr[25:20]);
                        illegal = !sh_hi_ok;
                    end else begin
                        imm     = XLEN'(instr[24:20]);
                        illegal = instr[25] || !sh_hi_ok;
                    end
                end else begin
                    fmt = FMT_I;
                    imm = XLEN'($signed(instr[31:20]));
                end
            end
            OPC_OP_IMM32: begin
                if (XLEN != 64) begin
                    illegal = 1'b1;
                end else if (is_sh) begin
                    fmt     = FMT_SH;
                    imm     = XLEN'(instr[24:20]);
                    illegal = instr[25] || !sh_hi_ok;
                end else begin
                    fmt = FMT_I;
                    imm = XLEN'($signed(instr[31:20]));
                end
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = XLEN'($signed({instr[31], instr[7],
                                     instr[30:25], instr[11:8],
                                     1'b0}));
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = XLEN'($signed({instr[31], instr[19:12],
                                     instr[20], instr[30:21],
                                     1'b0}));
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = XLEN'($signed({instr[31:12], 12'b0}));
            end
            OPC_SYSTEM: begin
                if (EN_ZICSR && f3[2]) begin
                    fmt = FMT_Z;
                    imm = XLEN'(instr[19:15]);
                end
            end
            OPC_OP, OPC_FENCE: begin
                illegal = 1'b0;
            end
            OPC_OP32: begin
                illegal = (XLEN != 64);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_pipe.sv
// Registered immediate-decode stage: decode, precompute target, then buffer
// in a main register plus one skid entry so in_ready is a pure flop.
module imm_decode_pipe
    import imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EN_ZICSR  = 1'b1,
    parameter bit EN_TARGET = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    input logic               flush,
    imm_decode_pipe_if.slave  bus
);

    if (!xlen_ok(XLEN)) begin : g_bad_xlen
        $error("imm_decode_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        fmt_t            fmt;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    fmt_t            dec_fmt;
    logic            dec_ill;
    logic            tgt_en;
    logic            acc;
    logic            pop;
    entry_t          new_e;
    entry_t          main_q, main_d;
    entry_t          skid_q, skid_d;
    pipe_state_t     state_q, state_d;
    logic            in_ready_q, in_ready_d;

    imm_decode_comb #(
        .XLEN     (XLEN),
        .EN_ZICSR (EN_ZICSR)
    ) u_dec (
        .instr   (bus.in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    // JALR target needs rs1, so only B, J and AUIPC get pc + imm here
    always_comb begin
        tgt_en = (dec_fmt == FMT_B) || (dec_fmt == FMT_J) ||
                 ((dec_fmt == FMT_U) &&
                  (bus.in_instr[6:0] == OPC_AUIPC));
        new_e.instr   = bus.in_instr;
        new_e.pc      = bus.in_pc;
        new_e.imm     = dec_imm;
        new_e.fmt     = dec_fmt;
        new_e.illegal = dec_ill;
        new_e.target  = (EN_TARGET && tgt_en) ?
                        (bus.in_pc + dec_imm) : '0;
    end

    always_comb begin
        acc     = bus.in_valid && in_ready_q;
        pop     = (state_q != ST_EMPTY) && bus.out_ready;
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d = ST_ONE;
                    main_d  = new_e;
                end
            end
            ST_ONE: begin
                if (acc && pop) begin
                    main_d = new_e;
                end else if (acc) begin
                    state_d = ST_FULL;
                    skid_d  = new_e;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = (state_q != ST_EMPTY);
    assign bus.out_instr   = main_q.instr;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_target  = main_q.target;
    assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench driving an XLEN=32 and an XLEN=64 stage with the same directed
// vectors; expected outputs are queued on accept and popped by a monitor.
module tb_imm_decode_pipe;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;

    always #5 clk = ~clk;

    imm_decode_pipe_if #(.XLEN(32)) bus32 ();
    imm_decode_pipe_if #(.XLEN(64)) bus64 ();

    assign bus32.in_valid  = in_valid;
    assign bus32.in_instr  = in_instr;
    assign bus32.in_pc     = in_pc[31:0];
    assign bus32.out_ready = out_ready;
    assign bus64.in_valid  = in_valid;
    assign bus64.in_instr  = in_instr;
    assign bus64.in_pc     = in_pc;
    assign bus64.out_ready = out_ready;

    imm_decode_pipe #(
        .XLEN(32), .EN_ZICSR(1'b1), .EN_TARGET(1'b1)
    ) u_d32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32.slave)
    );

    imm_decode_pipe #(
        .XLEN(64), .EN_ZICSR(1'b1), .EN_TARGET(1'b1)
    ) u_d64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64.slave)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [63:0] tgt;
        logic        ill;
    } rec_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm32;
        logic [2:0]  fmt32;
        logic [63:0] tgt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic [63:0] tgt64;
        logic        ill64;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];
    rec_t q32 [$];
    rec_t q64 [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_rec(input string tag, input rec_t a, input rec_t e);
        chk({tag, ".instr"}, 64'(a.instr), 64'(e.instr));
        chk({tag, ".pc"}, a.pc, e.pc);
        chk({tag, ".imm"}, a.imm, e.imm);
        chk({tag, ".fmt"}, 64'(a.fmt), 64'(e.fmt));
        chk({tag, ".target"}, a.tgt, e.tgt);
        chk({tag, ".illegal"}, 64'(a.ill), 64'(e.ill));
    endtask

    function automatic rec_t exp32(input int i);
        rec_t r;
        r.instr = vecs[i].instr;
        r.pc    = {32'b0, vecs[i].pc[31:0]};
        r.imm   = vecs[i].imm32;
        r.fmt   = vecs[i].fmt32;
        r.tgt   = vecs[i].tgt32;
        r.ill   = vecs[i].ill32;
        return r;
    endfunction

    function automatic rec_t exp64(input int i);
        rec_t r;
        r.instr = vecs[i].instr;
        r.pc    = vecs[i].pc;
        r.imm   = vecs[i].imm64;
        r.fmt   = vecs[i].fmt64;
        r.tgt   = vecs[i].tgt64;
        r.ill   = vecs[i].ill64;
        return r;
    endfunction

    function automatic rec_t act32();
        rec_t r;
        r.instr = bus32.out_instr;
        r.pc    = 64'(bus32.out_pc);
        r.imm   = 64'(bus32.out_imm);
        r.fmt   = bus32.out_fmt;
        r.tgt   = 64'(bus32.out_target);
        r.ill   = bus32.out_illegal;
        return r;
    endfunction

    function automatic rec_t act64();
        rec_t r;
        r.instr = bus64.out_instr;
        r.pc    = bus64.out_pc;
        r.imm   = bus64.out_imm;
        r.fmt   = bus64.out_fmt;
        r.tgt   = bus64.out_target;
        r.ill   = bus64.out_illegal;
        return r;
    endfunction

    // monitor: the displayed entry must match the queue head every cycle
    always @(negedge clk) begin
        if (rst_n && bus32.out_valid) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon32: unexpected entry %h",
                         bus32.out_instr);
            end else begin
                cmp_rec("d32", act32(), q32[0]);
                if (out_ready) void'(q32.pop_front());
            end
        end
        if (rst_n && bus64.out_valid) begin
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon64: unexpected entry %h",
                         bus64.out_instr);
            end else begin
                cmp_rec("d64", act64(), q64[0]);
                if (out_ready) void'(q64.pop_front());
            end
        end
    end

    task automatic send(input int i);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = vecs[i].instr;
        in_pc    = vecs[i].pc;
        while (!bus32.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus32.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send%0d: in_ready %b required 1", i,
                     bus32.in_ready);
            in_valid = 1'b0;
        end else begin
            q32.push_back(exp32(i));
            q64.push_back(exp64(i));
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'hFFF00093, 64'h100,
                     64'hFFFFFFFF, FMT_I, 64'h0, 1'b0,
                     64'hFFFFFFFFFFFFFFFF, FMT_I, 64'h0, 1'b0};
        vecs[1]  = '{32'hFE000CE3, 64'h200,
                     64'hFFFFFFF8, FMT_B, 64'h1F8, 1'b0,
                     64'hFFFFFFFFFFFFFFF8, FMT_B, 64'h1F8, 1'b0};
        vecs[2]  = '{32'h800000B7, 64'h300,
                     64'h80000000, FMT_U, 64'h0, 1'b0,
                     64'hFFFFFFFF80000000, FMT_U, 64'h0, 1'b0};
        vecs[3]  = '{32'h02809093, 64'h304,
                     64'h8, FMT_SH, 64'h0, 1'b1,
                     64'h28, FMT_SH, 64'h0, 1'b0};
        vecs[4]  = '{32'h0000000F, 64'h308,
                     64'h0, FMT_NONE, 64'h0, 1'b0,
                     64'h0, FMT_NONE, 64'h0, 1'b0};
        vecs[5]  = '{32'h00000000, 64'h30C,
                     64'h0, FMT_NONE, 64'h0, 1'b1,
                     64'h0, FMT_NONE, 64'h0, 1'b1};
        vecs[6]  = '{32'hFE20AE23, 64'h310,
                     64'hFFFFFFFC, FMT_S, 64'h0, 1'b0,
                     64'hFFFFFFFFFFFFFFFC, FMT_S, 64'h0, 1'b0};
        vecs[7]  = '{32'h001000EF, 64'h1000,
                     64'h800, FMT_J, 64'h1800, 1'b0,
                     64'h800, FMT_J, 64'h1800, 1'b0};
        vecs[8]  = '{32'h12345297, 64'h400,
                     64'h12345000, FMT_U, 64'h12345400, 1'b0,
                     64'h12345000, FMT_U, 64'h12345400, 1'b0};
        vecs[9]  = '{32'h3002D073, 64'h404,
                     64'h5, FMT_Z, 64'h0, 1'b0,
                     64'h5, FMT_Z, 64'h0, 1'b0};
        vecs[10] = '{32'h4030D093, 64'h408,
                     64'h3, FMT_SH, 64'h0, 1'b0,
                     64'h3, FMT_SH, 64'h0, 1'b0};
        vecs[11] = '{32'h0010809B, 64'h40C,
                     64'h0, FMT_NONE, 64'h0, 1'b1,
                     64'h1, FMT_I, 64'h0, 1'b0};
        vecs[12] = '{32'h01008067, 64'h410,
                     64'h10, FMT_I, 64'h0, 1'b0,
                     64'h10, FMT_I, 64'h0, 1'b0};
        vecs[13] = '{32'h002081B3, 64'h414,
                     64'h0, FMT_NONE, 64'h0, 1'b0,
                     64'h0, FMT_NONE, 64'h0, 1'b0};
        vecs[14] = '{32'h002081BB, 64'h418,
                     64'h0, FMT_NONE, 64'h0, 1'b1,
                     64'h0, FMT_NONE, 64'h0, 1'b0};
        vecs[15] = '{32'h00000073, 64'h41C,
                     64'h0, FMT_NONE, 64'h0, 1'b0,
                     64'h0, FMT_NONE, 64'h0, 1'b0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready32", 64'(bus32.in_ready), 64'd1);
        chk("rst_out_valid32", 64'(bus32.out_valid), 64'd0);
        chk("rst_fmt32", 64'(bus32.out_fmt), 64'(FMT_NONE));
        chk("rst_imm32", 64'(bus32.out_imm), 64'd0);
        chk("rst_in_ready64", 64'(bus64.in_ready), 64'd1);
        chk("rst_out_valid64", 64'(bus64.out_valid), 64'd0);
        chk("rst_illegal64", 64'(bus64.out_illegal), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // streaming with out_ready high, one-cycle latency
        out_ready = 1'b1;
        send(0);
        chk("latency_valid32", 64'(bus32.out_valid), 64'd1);
        chk("latency_valid64", 64'(bus64.out_valid), 64'd1);
        for (int i = 1; i < NV; i++) send(i);
        repeat (3) @(negedge clk);

        // backpressure: second accept fills the skid
        out_ready = 1'b0;
        send(1);
        chk("bp_ready_after1", 64'(bus32.in_ready), 64'd1);
        send(6);
        chk("bp_ready_after2_32", 64'(bus32.in_ready), 64'd0);
        chk("bp_ready_after2_64", 64'(bus64.in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_instr", 64'(bus32.out_instr), 64'(vecs[1].instr));
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_ready_back", 64'(bus32.in_ready), 64'd1);
        chk("bp_drained_valid", 64'(bus32.out_valid), 64'd0);
        chk("bp_q32_empty", 64'(q32.size()), 64'd0);
        chk("bp_q64_empty", 64'(q64.size()), 64'd0);

        // flush while FULL with a new entry offered
        out_ready = 1'b0;
        send(2);
        send(3);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = vecs[4].instr;
        in_pc    = vecs[4].pc;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        q32.delete();
        q64.delete();
        chk("flush_valid32", 64'(bus32.out_valid), 64'd0);
        chk("flush_ready32", 64'(bus32.in_ready), 64'd1);
        chk("flush_valid64", 64'(bus64.out_valid), 64'd0);
        chk("flush_ready64", 64'(bus64.in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // asynchronous reset mid-transfer
        out_ready = 1'b0;
        send(7);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = vecs[8].instr;
        in_pc    = vecs[8].pc;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        in_valid = 1'b0;
        q32.delete();
        q64.delete();
        chk("arst_valid32", 64'(bus32.out_valid), 64'd0);
        chk("arst_ready32", 64'(bus32.in_ready), 64'd1);
        chk("arst_imm32", 64'(bus32.out_imm), 64'd0);
        chk("arst_instr32", 64'(bus32.out_instr), 64'd0);
        chk("arst_pc32", 64'(bus32.out_pc), 64'd0);
        chk("arst_target32", 64'(bus32.out_target), 64'd0);
        chk("arst_fmt32", 64'(bus32.out_fmt), 64'(FMT_NONE));
        chk("arst_valid64", 64'(bus64.out_valid), 64'd0);
        chk("arst_target64", 64'(bus64.out_target), 64'd0);
        chk("arst_illegal64", 64'(bus64.out_illegal), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // recovery after reset
        send(8);
        repeat (3) @(negedge clk);
        chk("end_q32_empty", 64'(q32.size()), 64'd0);
        chk("end_q64_empty", 64'(q64.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
